// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared widths, scheduler state type and round-robin pick helper
package adder_sched_pkg;

    localparam int OP_WIDTH = 64;
    localparam int CNT_W    = 6;
    localparam int MAX_REQ  = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        START,
        GAP,
        SHIFT,
        WAIT_RDY,
        RESP
    } sched_state_t;

    // Returns the first set index in mask at or after last+1, wrapping modulo n.
    // Walking offsets from far to near lets the nearest candidate overwrite the others.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] mask, input logic [2:0] last, input int n);
        int k;
        rr_pick = '0;
        for (int i = MAX_REQ; i >= 1; i--) begin
            k = (int'(last) + i) % n;
            if (i <= n && mask[k]) rr_pick = 3'(k);
        end
    endfunction

endpackage

// File: rtl/adder_serial_scheduler_arb.sv
// rr_arbiter: one-hot round-robin grant starting after the previous winner
module rr_arbiter
    import adder_sched_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [2:0] pick;

    // Pick the next requester and expand it to a one-hot grant when enabled
    always_comb begin
        pick      = rr_pick(MAX_REQ'(req), 3'(last_grant), N);
        grant_idx = IW'(pick);
        grant     = (en && |req) ? (N'(1) << pick) : '0;
    end

endmodule

// File: rtl/adder_serial_scheduler.sv
// adder_serial_scheduler: time-shares one bit-serial adder among NUM_REQ requesters
module adder_serial_scheduler
    import adder_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int TIMEOUT = 256,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*OP_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*OP_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]          req_cin,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        resp_valid,
    output logic [IW-1:0]               resp_id,
    output logic [OP_WIDTH-1:0]         resp_sum,
    output logic                        resp_cout,
    output logic                        resp_err,
    output logic                        a_bit_in,
    output logic                        b_bit_in,
    output logic                        cin_in,
    output logic                        start_in,
    input  logic                        ready_out,
    input  logic [OP_WIDTH-1:0]         sum_out,
    input  logic                        cout_out,
    output logic                        busy
);

    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

    sched_state_t        state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic [TW-1:0]       timer;
    logic [IW-1:0]       last_grant;
    logic [IW-1:0]       grant_idx;
    logic [OP_WIDTH-1:0] a_reg;
    logic [OP_WIDTH-1:0] b_reg;
    logic                cin_reg;

    assign cnt_nx = cnt + 1'b1;

    // Grants are only offered while idle; held low during reset so req_ready reads 0
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .last_grant(last_grant),
        .en        (state == IDLE && rst_n),
        .grant     (req_ready),
        .grant_idx (grant_idx)
    );

    // Transaction FSM: grant, serialise the operands LSB first, then collect or time out the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            timer      <= '0;
            last_grant <= LAST_INIT;
            a_reg      <= '0;
            b_reg      <= '0;
            cin_reg    <= 1'b0;
            start_in   <= 1'b0;
            a_bit_in   <= 1'b0;
            b_bit_in   <= 1'b0;
            cin_in     <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_sum   <= '0;
            resp_cout  <= 1'b0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_ready) begin
                    a_reg      <= req_a[grant_idx*OP_WIDTH +: OP_WIDTH];
                    b_reg      <= req_b[grant_idx*OP_WIDTH +: OP_WIDTH];
                    cin_reg    <= req_cin[grant_idx];
                    last_grant <= grant_idx;
                    busy       <= 1'b1;
                    state      <= WAIT_IDLE;
                end
                WAIT_IDLE: if (!ready_out) begin
                    start_in <= 1'b1;
                    cin_in   <= cin_reg;
                    state    <= START;
                end
                START: begin
                    start_in <= 1'b0;
                    state    <= GAP;
                end
                GAP: begin
                    cnt      <= '0;
                    a_bit_in <= a_reg[0];
                    b_bit_in <= b_reg[0];
                    state    <= SHIFT;
                end
                SHIFT: begin
                    cnt      <= cnt_nx;
                    a_bit_in <= (&cnt) ? 1'b0 : a_reg[cnt_nx];
                    b_bit_in <= (&cnt) ? 1'b0 : b_reg[cnt_nx];
                    timer    <= '0;
                    state    <= (&cnt) ? WAIT_RDY : SHIFT;
                end
                WAIT_RDY: if (ready_out || timer == T_LAST) begin
                    resp_sum   <= ready_out ? sum_out : '0;
                    resp_cout  <= ready_out & cout_out;
                    resp_err   <= !ready_out;
                    resp_id    <= last_grant;
                    resp_valid <= 1'b1;
                    cin_in     <= 1'b0;
                    state      <= RESP;
                end else begin
                    timer <= timer + 1'b1;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_serial_scheduler.sv
// tb_adder_serial_scheduler: random and directed checks against a transaction-level model
module tb_adder_serial_scheduler;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int IW = $clog2(N);

    typedef struct {
        int         id;
        logic [64:0] res;
        bit         err;
        int         due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_cin = '0;
    logic [N-1:0]     req_ready;
    logic [N*64-1:0]  req_a = '0;
    logic [N*64-1:0]  req_b = '0;
    logic             resp_valid, resp_cout, resp_err, busy;
    logic [IW-1:0]    resp_id;
    logic [63:0]      resp_sum;
    logic             a_bit_in, b_bit_in, cin_in, start_in;
    logic             ready_out, cout_out, stub_rdy;
    logic [63:0]      sum_out, ga, gb;

    int   n_vec = 0, n_err = 0, n_resp = 0;
    int   cyc = 0, last = N - 1, last_acc = 0;
    int   phase, sc, dly, hold, stub_d, stub_h, stale_cnt = 0;
    bit   stub_never = 0, stale_mode = 0, rand_on = 0;
    exp_t exp_q[$];
    int   st_q[$];

    always #5 clk = ~clk;

    adder_serial_scheduler #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_id   (resp_id),
        .resp_sum  (resp_sum),
        .resp_cout (resp_cout),
        .resp_err  (resp_err),
        .a_bit_in  (a_bit_in),
        .b_bit_in  (b_bit_in),
        .cin_in    (cin_in),
        .start_in  (start_in),
        .ready_out (ready_out),
        .sum_out   (sum_out),
        .cout_out  (cout_out),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Behavioural serial adder: start, gap, 64 LSB-first bits, then ready after stub_d cycles for stub_h cycles
    assign ready_out = stub_rdy | (stale_cnt != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 0; sc <= 0; dly <= 0; hold <= 0;
            stub_rdy <= 1'b0; sum_out <= '0; cout_out <= 1'b0; ga <= '0; gb <= '0;
        end else if (start_in) begin
            phase <= 1;
        end else if (phase == 1) begin
            chk("gap_bits", {a_bit_in, b_bit_in}, 2'b00);
            phase <= 2;
            sc <= 0;
        end else if (phase == 2) begin
            ga <= {a_bit_in, ga[63:1]};
            gb <= {b_bit_in, gb[63:1]};
            if (sc == 63) begin
                {cout_out, sum_out} <= {1'b0, a_bit_in, ga[63:1]} + {1'b0, b_bit_in, gb[63:1]} + 65'(cin_in);
                if (!stub_never && stub_d == 0) begin
                    stub_rdy <= 1'b1; hold <= stub_h; phase <= 4;
                end else begin
                    dly <= 1; phase <= 3;
                end
            end else begin
                sc <= sc + 1;
            end
        end else if (phase == 3) begin
            if (stub_never) phase <= 0;
            else if (dly == stub_d) begin
                stub_rdy <= 1'b1; hold <= stub_h; phase <= 4;
            end else dly <= dly + 1;
        end else if (phase == 4) begin
            if (hold == 1) begin
                stub_rdy <= 1'b0; phase <= 0;
            end else hold <= hold - 1;
        end
    end

    function automatic logic [63:0] rnd64();
        case ($urandom_range(3))
            0:       return '1;
            1:       return '0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input logic c);
        req_a[i*64 +: 64] = a;
        req_b[i*64 +: 64] = b;
        req_cin[i]        = c;
        req_valid[i]      = 1'b1;
    endtask

    // One clock: observe at negedge against the model, then drive just after the rising edge
    task automatic tick();
        int g, extra;
        bit busy_m;
        exp_t e;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        busy_m = exp_q.size() != 0;
        chk("busy", busy, busy_m);
        if (start_in) begin
            if (st_q.size() == 0) chk("start_unexpected", start_in, 1'b0);
            else chk("start_cycle", cyc, st_q.pop_front());
        end
        if (resp_valid) begin
            if (exp_q.size() == 0) chk("resp_unexpected", resp_valid, 1'b0);
            else begin
                e = exp_q.pop_front();
                chk("resp_id", resp_id, e.id);
                chk("resp_sum", resp_sum, e.res[63:0]);
                chk("resp_cout", resp_cout, e.res[64]);
                chk("resp_err", resp_err, e.err);
                chk("resp_cycle", cyc, e.due);
                n_resp++;
            end
        end
        g = -1;
        if (rst_n) begin
            for (int k = 1; k <= N; k++)
                if (g < 0 && !busy_m && req_valid[(last + k) % N]) g = (last + k) % N;
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            if (g >= 0) begin
                extra    = stale_mode ? 5 : 0;
                stub_d   = $urandom_range(5);
                stub_h   = $urandom_range(1, 3);
                e.id     = g;
                e.err    = stub_never;
                e.res    = stub_never ? 65'd0 : {1'b0, req_a[g*64 +: 64]} + {1'b0, req_b[g*64 +: 64]} + 65'(req_cin[g]);
                e.due    = cyc + extra + (stub_never ? 68 + TO : 69 + stub_d);
                exp_q.push_back(e);
                st_q.push_back(cyc + 2 + extra);
                last     = g;
                last_acc = cyc;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (stale_cnt > 0) stale_cnt--;
        if (g >= 0) begin
            req_valid[g] = 1'b0;
            if (stale_mode) stale_cnt = 5;
            if (rand_on && (g == 0 || $urandom_range(1) == 1)) set_req(g, rnd64(), rnd64(), 1'($urandom_range(1)));
        end
        if (rand_on)
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(15) == 0) set_req(i, rnd64(), rnd64(), 1'($urandom_range(1)));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || |req_valid) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_pending", exp_q.size() + int'(|req_valid), 0);
    endtask

    task automatic chk_rst();
        chk("rst_req_ready", req_ready, '0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_id", resp_id, '0);
        chk("rst_resp_sum", resp_sum, '0);
        chk("rst_resp_cout", resp_cout, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_bits", {a_bit_in, b_bit_in, cin_in, start_in}, 4'b0);
        chk("rst_busy", busy, 1'b0);
    endtask

    task automatic clear_model();
        exp_q = {};
        st_q = {};
        req_valid = '0;
        last = N - 1;
        stale_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) tick();
        chk_rst();
        rst_n = 1'b1;
        // single request from requester 2
        set_req(2, 64'h1, 64'h0, 1'b0);
        drain(400);
        // all requesters at once from a fresh reset: grants 0,1,2,3
        do_reset();
        set_req(0, '1, 64'h1, 1'b0);
        set_req(1, '1, '1, 1'b1);
        set_req(2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        set_req(3, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
        drain(800);
        // adder never answers, then a normal transaction
        stub_never = 1;
        set_req(1, rnd64(), rnd64(), 1'b1);
        drain(300);
        stub_never = 0;
        set_req(3, rnd64(), rnd64(), 1'b0);
        drain(300);
        // stale ready held 5 cycles after the grant delays start
        stale_mode = 1;
        set_req(0, rnd64(), rnd64(), 1'b1);
        drain(300);
        stale_mode = 0;
        // reset while shifting bit 30
        do_reset();
        set_req(2, '1, '1, 1'b1);
        for (int n = 0; n < 20 && st_q.size() == 0; n++) tick();
        while (cyc < last_acc + 34) tick();
        #2 rst_n = 1'b0;
        #1 chk_rst();
        clear_model();
        repeat (3) tick();
        rst_n = 1'b1;
        set_req(1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
        drain(300);
        // random traffic with requester 0 always pending
        begin
            int n0 = n_resp;
            int n = 0;
            rand_on = 1;
            set_req(0, rnd64(), rnd64(), 1'($urandom_range(1)));
            while (n_resp - n0 < 150 && n < 20000) begin
                tick();
                n++;
            end
            rand_on = 0;
            chk("rand_count", (n_resp - n0) >= 150, 1'b1);
            drain(3000);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
